// File: rtl/joy_pkg.sv
// Shared constants for the joystick tracker: direction indices and default screen bounds.
package joy_pkg;

    localparam int unsigned DIR_LEFT      = 0;
    localparam int unsigned DIR_RIGHT     = 1;
    localparam int unsigned DIR_UP        = 2;
    localparam int unsigned DIR_DOWN      = 3;
    localparam int unsigned NUM_DIRS      = 4;

    localparam int          X_MAX_DEFAULT = 639;
    localparam int          Y_MAX_DEFAULT = 479;

endpackage

// File: rtl/joy_if.sv
// Joystick/video-side bundle: raw joystick lines and vsync in, live and frame-latched position out.
interface joy_if #(
    parameter int W = 10
);

    logic         left;
    logic         right;
    logic         up;
    logic         down;
    logic         vsync;
    logic [W-1:0] joy_x;
    logic [W-1:0] joy_y;
    logic [W-1:0] player_x;
    logic [W-1:0] player_y;
    logic         frame_strobe;

    modport master (
        output left, right, up, down, vsync,
        input  joy_x, joy_y, player_x, player_y, frame_strobe
    );

    modport slave (
        input  left, right, up, down, vsync,
        output joy_x, joy_y, player_x, player_y, frame_strobe
    );

endinterface

// File: rtl/joy_debounce.sv
// One joystick line: 2-flop synchronizer followed by a tick-sampled stability filter.
module joy_debounce #(
    parameter int DB_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic state
);

    localparam int CW = (DB_TICKS > 1) ? $clog2(DB_TICKS + 1) : 1;

    logic          sync1_r;
    logic          sync2_r;
    logic          state_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, then accept a change only after DB_TICKS consecutive disagreeing ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            state_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (tick) begin
                if (sync2_r != state_r) begin
                    if (cnt_r == CW'(DB_TICKS - 1)) begin
                        state_r <= sync2_r;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end else begin
                    cnt_r <= {CW{1'b0}};
                end
            end
        end
    end

    assign state = state_r;

endmodule

// File: rtl/joy_tracker.sv
// Joystick position tracker: tick-paced debounced motion with clamping, latched into player_x/y on vsync.
// Optional acceleration after a long hold is enabled by defining JOY_ACCEL_EN.
module joy_tracker
    import joy_pkg::*;
#(
    parameter int W           = 10,
    parameter int X_MAX       = X_MAX_DEFAULT,
    parameter int Y_MAX       = Y_MAX_DEFAULT,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int TICK_DIV    = 250000,
    parameter int DB_TICKS    = 3,
    parameter int STEP        = 1,
    parameter int ACCEL_TICKS = 50
) (
    input  logic clk,
    input  logic reset,
    joy_if.slave bus
);

    localparam int           TW     = $clog2(TICK_DIV);
    localparam logic [W:0]   X_LIM  = (W+1)'(X_MAX);
    localparam logic [W:0]   Y_LIM  = (W+1)'(Y_MAX);
    localparam logic [W:0]   STEP_1 = (W+1)'(STEP);
    localparam logic [W-1:0] X_RST  = W'(X_INIT);
    localparam logic [W-1:0] Y_RST  = W'(Y_INIT);

    if (X_INIT > X_MAX || Y_INIT > Y_MAX || TICK_DIV < 2 || DB_TICKS < 1 || ACCEL_TICKS < 1) begin : g_bad_params
        $error("joy_tracker: illegal parameter combination");
    end

    // Move one axis by stp in W+1 bits, clamping to [0, lim]; both or neither direction holds position.
    function automatic logic [W-1:0] sat_move(input logic [W-1:0] cur, input logic dec,
                                              input logic inc, input logic [W:0] stp,
                                              input logic [W:0] lim);
        logic [W:0] wide_s;
        logic [W:0] res_s;
        wide_s = {1'b0, cur};
        if (dec && !inc) begin
            if (wide_s < stp) begin
                res_s = {(W+1){1'b0}};
            end else begin
                res_s = wide_s - stp;
            end
        end else if (inc && !dec) begin
            res_s = wide_s + stp;
            if (res_s > lim) begin
                res_s = lim;
            end else begin
                res_s = res_s;
            end
        end else begin
            res_s = wide_s;
        end
        return res_s[W-1:0];
    endfunction

    logic [TW-1:0]       tick_cnt_r;
    logic                tick_s;
    logic [NUM_DIRS-1:0] raw_s;
    logic [NUM_DIRS-1:0] db_s;
    logic [W:0]          step_x_s;
    logic [W:0]          step_y_s;
    logic [W-1:0]        next_x_s;
    logic [W-1:0]        next_y_s;
    logic [W-1:0]        joy_x_r;
    logic [W-1:0]        joy_y_r;
    logic [W-1:0]        player_x_r;
    logic [W-1:0]        player_y_r;
    logic                strobe_r;
    logic                vs1_r;
    logic                vs2_r;
    logic                vs_prev_r;
    logic                vs_rise_s;

    assign tick_s = (tick_cnt_r == TW'(TICK_DIV - 1));

    // Free-running motion tick divider; tick_s is a clock enable, never a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_r <= {TW{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    assign raw_s[DIR_LEFT]  = bus.left;
    assign raw_s[DIR_RIGHT] = bus.right;
    assign raw_s[DIR_UP]    = bus.up;
    assign raw_s[DIR_DOWN]  = bus.down;

    for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
        joy_debounce #(
            .DB_TICKS (DB_TICKS)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_s[d]),
            .tick  (tick_s),
            .state (db_s[d])
        );
    end

`ifdef JOY_ACCEL_EN
    localparam int              HW       = $clog2(ACCEL_TICKS + 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(ACCEL_TICKS);
    localparam logic [W:0]      STEP_2   = (W+1)'(2 * STEP);

    logic [HW-1:0] hold_x_r;
    logic [HW-1:0] hold_y_r;
    logic          dir_x_r;
    logic          dir_y_r;
    logic          move_x_s;
    logic          move_y_s;

    // dir_*_r remembers the last moving direction: 1 = right/down, 0 = left/up.
    assign move_x_s = db_s[DIR_LEFT] ^ db_s[DIR_RIGHT];
    assign move_y_s = db_s[DIR_UP] ^ db_s[DIR_DOWN];

    // Double the step once the same direction has been held for ACCEL_TICKS motion ticks.
    always_comb begin
        step_x_s = STEP_1;
        step_y_s = STEP_1;
        if (move_x_s && (dir_x_r == db_s[DIR_RIGHT]) && (hold_x_r >= HOLD_MAX)) begin
            step_x_s = STEP_2;
        end else begin
            step_x_s = STEP_1;
        end
        if (move_y_s && (dir_y_r == db_s[DIR_DOWN]) && (hold_y_r >= HOLD_MAX)) begin
            step_y_s = STEP_2;
        end else begin
            step_y_s = STEP_1;
        end
    end

    // Hold counters: restart on a new direction, clear on release or both pressed, saturate at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_x_r <= {HW{1'b0}};
            hold_y_r <= {HW{1'b0}};
            dir_x_r  <= 1'b0;
            dir_y_r  <= 1'b0;
        end else if (tick_s) begin
            if (move_x_s) begin
                if ((hold_x_r != {HW{1'b0}}) && (dir_x_r == db_s[DIR_RIGHT])) begin
                    if (hold_x_r < HOLD_MAX) begin
                        hold_x_r <= hold_x_r + HW'(1);
                    end
                end else begin
                    hold_x_r <= HW'(1);
                end
                dir_x_r <= db_s[DIR_RIGHT];
            end else begin
                hold_x_r <= {HW{1'b0}};
            end
            if (move_y_s) begin
                if ((hold_y_r != {HW{1'b0}}) && (dir_y_r == db_s[DIR_DOWN])) begin
                    if (hold_y_r < HOLD_MAX) begin
                        hold_y_r <= hold_y_r + HW'(1);
                    end
                end else begin
                    hold_y_r <= HW'(1);
                end
                dir_y_r <= db_s[DIR_DOWN];
            end else begin
                hold_y_r <= {HW{1'b0}};
            end
        end
    end
`else
    assign step_x_s = STEP_1;
    assign step_y_s = STEP_1;
`endif

    assign next_x_s = sat_move(joy_x_r, db_s[DIR_LEFT], db_s[DIR_RIGHT], step_x_s, X_LIM);
    assign next_y_s = sat_move(joy_y_r, db_s[DIR_UP], db_s[DIR_DOWN], step_y_s, Y_LIM);

    // Live position advances only on motion ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            joy_x_r <= X_RST;
            joy_y_r <= Y_RST;
        end else if (tick_s) begin
            joy_x_r <= next_x_s;
            joy_y_r <= next_y_s;
        end
    end

    assign vs_rise_s = vs2_r & ~vs_prev_r;

    // Frame latch samples the registered live position, so a coincident update lands next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs1_r      <= 1'b0;
            vs2_r      <= 1'b0;
            vs_prev_r  <= 1'b0;
            player_x_r <= X_RST;
            player_y_r <= Y_RST;
            strobe_r   <= 1'b0;
        end else begin
            vs1_r     <= bus.vsync;
            vs2_r     <= vs1_r;
            vs_prev_r <= vs2_r;
            if (vs_rise_s) begin
                player_x_r <= joy_x_r;
                player_y_r <= joy_y_r;
                strobe_r   <= 1'b1;
            end else begin
                strobe_r   <= 1'b0;
            end
        end
    end

    assign bus.joy_x        = joy_x_r;
    assign bus.joy_y        = joy_y_r;
    assign bus.player_x     = player_x_r;
    assign bus.player_y     = player_y_r;
    assign bus.frame_strobe = strobe_r;

endmodule

// File: tb/tb_joy_tracker.sv
// Directed bench for joy_tracker with TICK_DIV=4, DB_TICKS=2; acceleration checks only when JOY_ACCEL_EN is defined.
module tb_joy_tracker;

    logic clk;
    logic reset;
    int   edge_n;
    int   base;
    int   tests_run;
    int   failed;

    joy_if #(.W(10)) if0 ();
    joy_if #(.W(10)) if_hi ();
    joy_if #(.W(10)) if_lo ();

    joy_tracker #(.W(10), .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240),
                  .TICK_DIV(4), .DB_TICKS(2), .STEP(1), .ACCEL_TICKS(4))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    joy_tracker #(.W(10), .X_MAX(639), .Y_MAX(479), .X_INIT(638), .Y_INIT(479),
                  .TICK_DIV(4), .DB_TICKS(2), .STEP(1), .ACCEL_TICKS(4))
        dut_hi (.clk(clk), .reset(reset), .bus(if_hi));
    joy_tracker #(.W(10), .X_MAX(639), .Y_MAX(479), .X_INIT(0), .Y_INIT(0),
                  .TICK_DIV(4), .DB_TICKS(2), .STEP(1), .ACCEL_TICKS(4))
        dut_lo (.clk(clk), .reset(reset), .bus(if_lo));

`ifdef JOY_ACCEL_EN
    joy_if #(.W(10)) if_acc ();
    joy_tracker #(.W(10), .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240),
                  .TICK_DIV(4), .DB_TICKS(2), .STEP(1), .ACCEL_TICKS(4))
        dut_acc (.clk(clk), .reset(reset), .bus(if_acc));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic clear_inputs;
        if0.left = 1'b0;   if0.right = 1'b0;   if0.up = 1'b0;   if0.down = 1'b0;   if0.vsync = 1'b0;
        if_hi.left = 1'b0; if_hi.right = 1'b0; if_hi.up = 1'b0; if_hi.down = 1'b0; if_hi.vsync = 1'b0;
        if_lo.left = 1'b0; if_lo.right = 1'b0; if_lo.up = 1'b0; if_lo.down = 1'b0; if_lo.vsync = 1'b0;
`ifdef JOY_ACCEL_EN
        if_acc.left = 1'b0; if_acc.right = 1'b0; if_acc.up = 1'b0; if_acc.down = 1'b0; if_acc.vsync = 1'b0;
`endif
    endtask

    // Release lands on a falling edge; edges are then counted 1, 2, ... and ticks act on multiples of 4.
    task automatic apply_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        base = edge_n;
    endtask

    task automatic wait_edge(input int n);
        while ((edge_n - base) < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        int n;
        clear_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (if0.joy_x !== 10'd320 || if0.joy_y !== 10'd240) begin
            failed++; $display("FAIL reset_joy: got (%0d,%0d) expected (320,240)", if0.joy_x, if0.joy_y);
        end
        tests_run++;
        if (if0.player_x !== 10'd320 || if0.player_y !== 10'd240 || if0.frame_strobe !== 1'b0) begin
            failed++; $display("FAIL reset_player: got (%0d,%0d,%0b) expected (320,240,0)",
                               if0.player_x, if0.player_y, if0.frame_strobe);
        end
        tests_run++;
        if (if_hi.joy_x !== 10'd638 || if_lo.joy_y !== 10'd0) begin
            failed++; $display("FAIL reset_init_params: got (%0d,%0d) expected (638,0)", if_hi.joy_x, if_lo.joy_y);
        end
        apply_reset();
        n = 0;
        for (int e = 1; e <= 40; e++) begin
            wait_edge(e);
            if (if0.frame_strobe !== 1'b0) n++;
        end
        tests_run++;
        if (n != 0) begin
            failed++; $display("FAIL idle_strobe: got %0d strobes expected 0", n);
        end
        tests_run++;
        if (if0.joy_x !== 10'd320 || if0.joy_y !== 10'd240 || if0.player_x !== 10'd320) begin
            failed++; $display("FAIL idle_hold: got (%0d,%0d,%0d) expected (320,240,320)",
                               if0.joy_x, if0.joy_y, if0.player_x);
        end
    endtask

    task automatic test_move_right;
        clear_inputs();
        if0.right = 1'b1;
        apply_reset();
        wait_edge(10);
        tests_run++;
        if (if0.joy_x !== 10'd320) begin
            failed++; $display("FAIL right_debounce_latency: got %0d expected 320", if0.joy_x);
        end
        wait_edge(14);
        tests_run++;
        if (if0.joy_x !== 10'd321) begin
            failed++; $display("FAIL right_first_step: got %0d expected 321", if0.joy_x);
        end
        wait_edge(42);
        tests_run++;
        if (if0.joy_x !== 10'd328 || if0.joy_y !== 10'd240) begin
            failed++; $display("FAIL right_ten_ticks: got (%0d,%0d) expected (328,240)", if0.joy_x, if0.joy_y);
        end
    endtask

    task automatic test_glitch;
        clear_inputs();
        if0.right = 1'b1;
        apply_reset();
        wait_edge(4);
        if0.right = 1'b0;
        wait_edge(42);
        tests_run++;
        if (if0.joy_x !== 10'd320) begin
            failed++; $display("FAIL glitch_ignored: got %0d expected 320", if0.joy_x);
        end
    endtask

    task automatic test_saturate;
        clear_inputs();
        if_hi.right = 1'b1;
        if_hi.down  = 1'b1;
        if_lo.left  = 1'b1;
        if_lo.up    = 1'b1;
        if0.left    = 1'b1;
        if0.right   = 1'b1;
        apply_reset();
        wait_edge(14);
        tests_run++;
        if (if_hi.joy_x !== 10'd639) begin
            failed++; $display("FAIL sat_hi_first: got %0d expected 639", if_hi.joy_x);
        end
        wait_edge(30);
        tests_run++;
        if (if_hi.joy_x !== 10'd639 || if_hi.joy_y !== 10'd479) begin
            failed++; $display("FAIL sat_hi_hold: got (%0d,%0d) expected (639,479)", if_hi.joy_x, if_hi.joy_y);
        end
        tests_run++;
        if (if_lo.joy_x !== 10'd0 || if_lo.joy_y !== 10'd0) begin
            failed++; $display("FAIL sat_lo_hold: got (%0d,%0d) expected (0,0)", if_lo.joy_x, if_lo.joy_y);
        end
        tests_run++;
        if (if0.joy_x !== 10'd320) begin
            failed++; $display("FAIL both_pressed: got %0d expected 320", if0.joy_x);
        end
    endtask

    task automatic test_diagonal_vsync;
        int n;
        clear_inputs();
        if0.up    = 1'b1;
        if0.right = 1'b1;
        apply_reset();
        wait_edge(10);
        tests_run++;
        if (if0.joy_x !== 10'd320 || if0.joy_y !== 10'd240) begin
            failed++; $display("FAIL diag_before: got (%0d,%0d) expected (320,240)", if0.joy_x, if0.joy_y);
        end
        wait_edge(14);
        tests_run++;
        if (if0.joy_x !== 10'd321 || if0.joy_y !== 10'd239) begin
            failed++; $display("FAIL diag_same_tick: got (%0d,%0d) expected (321,239)", if0.joy_x, if0.joy_y);
        end
        wait_edge(18);
        if0.vsync = 1'b1;
        wait_edge(20);
        tests_run++;
        if (if0.frame_strobe !== 1'b0) begin
            failed++; $display("FAIL vsync_sync_delay: got %0b expected 0", if0.frame_strobe);
        end
        wait_edge(21);
        tests_run++;
        if (if0.frame_strobe !== 1'b1 || if0.player_x !== 10'd323 || if0.player_y !== 10'd237) begin
            failed++; $display("FAIL vsync_capture: got (%0b,%0d,%0d) expected (1,323,237)",
                               if0.frame_strobe, if0.player_x, if0.player_y);
        end
        n = 0;
        for (int e = 22; e <= 40; e++) begin
            wait_edge(e);
            if (if0.frame_strobe !== 1'b0) n++;
        end
        tests_run++;
        if (n != 0) begin
            failed++; $display("FAIL vsync_held_no_restrobe: got %0d strobes expected 0", n);
        end
        if0.vsync = 1'b0;
        wait_edge(44);
        if0.vsync = 1'b1;
        wait_edge(47);
        tests_run++;
        if (if0.frame_strobe !== 1'b1 || if0.player_x !== 10'd329 || if0.player_y !== 10'd231) begin
            failed++; $display("FAIL vsync_second: got (%0b,%0d,%0d) expected (1,329,231)",
                               if0.frame_strobe, if0.player_x, if0.player_y);
        end
        wait_edge(48);
        tests_run++;
        if (if0.frame_strobe !== 1'b0) begin
            failed++; $display("FAIL strobe_one_cycle: got %0b expected 0", if0.frame_strobe);
        end
        if0.vsync = 1'b0;
    endtask

    task automatic test_back_to_back;
        wait_edge(49);
        if0.vsync = 1'b1;
        wait_edge(52);
        tests_run++;
        if (if0.player_x !== 10'd330 || if0.player_y !== 10'd230 || if0.frame_strobe !== 1'b1) begin
            failed++; $display("FAIL coincident_old_value: got (%0d,%0d,%0b) expected (330,230,1)",
                               if0.player_x, if0.player_y, if0.frame_strobe);
        end
        tests_run++;
        if (if0.joy_x !== 10'd331 || if0.joy_y !== 10'd229) begin
            failed++; $display("FAIL coincident_joy: got (%0d,%0d) expected (331,229)", if0.joy_x, if0.joy_y);
        end
        wait_edge(53);
        if0.vsync = 1'b0;
        wait_edge(57);
        if0.vsync = 1'b1;
        wait_edge(60);
        tests_run++;
        if (if0.player_x !== 10'd332 || if0.player_y !== 10'd228 || if0.frame_strobe !== 1'b1) begin
            failed++; $display("FAIL coincident_next_frame: got (%0d,%0d,%0b) expected (332,228,1)",
                               if0.player_x, if0.player_y, if0.frame_strobe);
        end
    endtask

    task automatic test_async_reset;
        wait_edge(62);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (if0.joy_x !== 10'd320 || if0.joy_y !== 10'd240 || if0.player_x !== 10'd320 ||
            if0.player_y !== 10'd240 || if0.frame_strobe !== 1'b0) begin
            failed++; $display("FAIL async_reset: got (%0d,%0d,%0d,%0d,%0b) expected (320,240,320,240,0)",
                               if0.joy_x, if0.joy_y, if0.player_x, if0.player_y, if0.frame_strobe);
        end
        clear_inputs();
        apply_reset();
    endtask

`ifdef JOY_ACCEL_EN
    task automatic test_accel;
        clear_inputs();
        if_acc.right = 1'b1;
        apply_reset();
        wait_edge(26);
        tests_run++;
        if (if_acc.joy_x !== 10'd324) begin
            failed++; $display("FAIL accel_slow_phase: got %0d expected 324", if_acc.joy_x);
        end
        wait_edge(30);
        tests_run++;
        if (if_acc.joy_x !== 10'd326) begin
            failed++; $display("FAIL accel_first_fast: got %0d expected 326", if_acc.joy_x);
        end
        wait_edge(32);
        if_acc.right = 1'b0;
        wait_edge(34);
        tests_run++;
        if (if_acc.joy_x !== 10'd328) begin
            failed++; $display("FAIL accel_second_fast: got %0d expected 328", if_acc.joy_x);
        end
        wait_edge(40);
        if_acc.right = 1'b1;
        wait_edge(50);
        tests_run++;
        if (if_acc.joy_x !== 10'd332) begin
            failed++; $display("FAIL accel_release: got %0d expected 332", if_acc.joy_x);
        end
        wait_edge(54);
        tests_run++;
        if (if_acc.joy_x !== 10'd333) begin
            failed++; $display("FAIL accel_repress_slow: got %0d expected 333", if_acc.joy_x);
        end
        wait_edge(58);
        tests_run++;
        if (if_acc.joy_x !== 10'd334) begin
            failed++; $display("FAIL accel_repress_slow2: got %0d expected 334", if_acc.joy_x);
        end
    endtask
`endif

    initial begin
        tests_run = 0;
        failed    = 0;
        base      = 0;
        reset     = 1'b0;
        clear_inputs();
        test_reset();
        test_move_right();
        test_glitch();
        test_saturate();
        test_diagonal_vsync();
        test_back_to_back();
        test_async_reset();
`ifdef JOY_ACCEL_EN
        test_accel();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/joy_tracker.md
JOY_TRACKER -- requirements
Module: joy_tracker

Interface
REQ-001 Parameter W, default 10: coordinate width in bits.
REQ-002 Parameter X_MAX, default 639: inclusive upper x bound.
REQ-003 Parameter Y_MAX, default 479: inclusive upper y bound.
REQ-004 Parameter X_INIT / Y_INIT, default 320 / 240: reset position; must be <= X_MAX / Y_MAX.
REQ-005 Parameter TICK_DIV, default 250000: clk cycles per motion tick (100 Hz at 25 MHz); must be >= 2.
REQ-006 Parameter DB_TICKS, default 3: consecutive stable ticks required to accept a direction change; must be >= 1.
REQ-007 Parameter STEP, default 1: pixels moved per tick per axis.
REQ-008 Parameter ACCEL_TICKS, default 50: held ticks before acceleration; used only with JOY_ACCEL_EN.
REQ-009 clk  in  1  system clock; the only clock in the block.
REQ-010 reset  in  1  asynchronous, active-low reset.
REQ-011 left, right, up, down  in  1 each  raw joystick lines, active-high, asynchronous to clk.
REQ-012 vsync  in  1  frame sync from the video timing generator, asynchronous-safe; the rising edge marks the frame boundary.
REQ-013 joy_x, joy_y  out  W each  live position.
REQ-014 player_x, player_y  out  W each  position latched at the frame boundary.
REQ-015 frame_strobe  out  1  one-cycle pulse when player_x/player_y update.

Function
REQ-016 Each of left/right/up/down/vsync SHALL pass through a 2-flop synchronizer before any use.
REQ-017 Tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert the internal tick for exactly one clk when at TICK_DIV-1. No derived clocks; tick is a clock enable.
REQ-018 Per direction, the debounced state SHALL change only after the synchronized input differs from it on DB_TICKS consecutive ticks; any agreeing tick restarts the count.
REQ-019 Axes SHALL be independent; diagonal motion is allowed on a single tick.
REQ-020 Per axis on a tick: negative only -> subtract step; positive only -> add step; both or neither -> no change.
REQ-021 Arithmetic in W+1 bits with saturation: x-step < 0 -> 0; x+step > X_MAX -> X_MAX; same for y with Y_MAX. Never wraps.
REQ-022 joy_x/joy_y SHALL update one clk after the tick in which motion is decided.
REQ-023 On the clk after a synchronized vsync 0->1 transition, player_x/player_y <= joy_x/joy_y and frame_strobe = 1 for exactly that clk.
REQ-024 Vsync edge and position update in the same clk: player captures the pre-update (registered) joy value.
REQ-025 Vsync held high SHALL produce no further strobes until it falls and rises again.

Reset
REQ-026 While reset=0: joy and player = X_INIT/Y_INIT, frame_strobe=0, tick counter=0, synchronizers and debounced states=0, debounce/accel counters=0.
REQ-027 Reset assertion mid-motion SHALL take effect immediately (async); the first tick after release occurs TICK_DIV clks later.

Configuration
REQ-028 Macro JOY_ACCEL_EN defined: per-axis hold counter counts ticks of unbroken same-direction motion; from tick ACCEL_TICKS onward the step is 2*STEP; release, reversal, or both pressed clears the counter and restores STEP.
REQ-029 JOY_ACCEL_EN undefined: step is always STEP; hold counters and ACCEL_TICKS have no logic.

Structure
REQ-030 Shared package joy_pkg SHALL hold the direction index constants (DIR_LEFT=0, DIR_RIGHT=1, DIR_UP=2, DIR_DOWN=3) and the default screen bounds 639/479.
REQ-031 Sub-module joy_debounce (synchronizer + stable-tick counter, one bit) SHALL be instanced once per direction; tick generator, motion/clamp, and frame latch stay in joy_tracker.

Verification (TICK_DIV=4, DB_TICKS=2, STEP=1 unless stated)
REQ-032 Reset release, no input -> joy=(320,240), player=(320,240), frame_strobe=0 indefinitely.
REQ-033 right held 10 ticks -> joy_x 320 then, after debounce latency, +1 per tick; a 1-tick right glitch -> no movement.
REQ-034 X_INIT=638, right held -> joy_x saturates at 639; X_INIT=0, left held -> stays 0; left+right held -> x unchanged.
REQ-035 up+right held -> x+1 and y-1 on the same tick; vsync pulse -> player matches joy one clk after the synchronized edge, single frame_strobe.
REQ-036 Vsync edge coincident with update -> player gets the old joy value; the next vsync gets the new value.
REQ-037 JOY_ACCEL_EN, ACCEL_TICKS=4, right held -> +1 per tick for 4 ticks, then +2 per tick; release 1 tick then re-press -> back to +1.
